instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter INST_WIDTH, default 32, SHALL set the instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the PC and memory address width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC loaded on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 redirect_valid  input  1  SHALL signal a branch/jump redirect this cycle.
REQ-007 redirect_pc  input  ADDR_WIDTH  SHALL be the redirect target.
REQ-008 buf_full  input  1  SHALL be the downstream instruction buffer full flag.
REQ-009 imem_req_valid  output  1  SHALL indicate a fetch request.
REQ-010 imem_req_ready  input  1  SHALL indicate that memory accepts the request.
REQ-011 imem_req_addr  output  ADDR_WIDTH  SHALL be the request address, equal to the current PC.
REQ-012 imem_resp_valid  input  1  SHALL indicate that response data is valid.
REQ-013 imem_resp_data  input  INST_WIDTH  SHALL be the fetched instruction.
REQ-014 buf_write_en  output  1  SHALL be the write strobe into the instruction buffer.
REQ-015 buf_data  output  INST_WIDTH  SHALL be the instruction written to the buffer.
REQ-016 fetch_pc  output  ADDR_WIDTH  SHALL be the PC of the instruction on buf_data.

Function
REQ-017 The FSM SHALL have exactly three states: REQ (issue), WAIT (one request outstanding) and DROP (discard a stale response).
REQ-018 In REQ, imem_req_valid SHALL be asserted iff buf_full=0, buf_write_en=0 and redirect_valid=0; the signal is combinational.
REQ-019 In REQ, a handshake (valid & ready) SHALL move the FSM to WAIT and latch the request address; no handshake SHALL leave the FSM in REQ with the PC held.
REQ-020 At most one request SHALL be outstanding, so buffer space is guaranteed when the response returns.
REQ-021 In WAIT, imem_resp_valid with no redirect SHALL register buf_write_en=1, buf_data=imem_resp_data and fetch_pc=latched address on the next edge, set PC to PC+4 and return to REQ.
REQ-022 buf_write_en SHALL be a single-cycle pulse, one cycle after imem_resp_valid.
REQ-023 A redirect in REQ SHALL load PC with redirect_pc (bits [1:0] forced to 0) and suppress that cycle's request; the FSM SHALL stay in REQ.
REQ-024 A redirect in WAIT without imem_resp_valid SHALL load PC and move the FSM to DROP.
REQ-025 A redirect in WAIT coincident with imem_resp_valid SHALL discard the response (no buf_write_en), load PC and move the FSM to REQ.
REQ-026 In DROP, imem_resp_valid SHALL be discarded and the FSM SHALL move to REQ; a redirect in DROP SHALL reload PC and leave the FSM in DROP unless the response arrives in the same cycle.
REQ-027 PC arithmetic SHALL wrap modulo 2^ADDR_WIDTH; for ADDR_WIDTH=32, PC 0xFFFFFFFC + 4 = 0x00000000.
REQ-028 Responses arriving in REQ SHALL be ignored.

Reset
REQ-029 Asserting reset SHALL immediately force PC=RESET_PC, state=REQ, buf_write_en=0, buf_data=0, fetch_pc=0 and imem_req_valid=0.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding request; any later response SHALL be ignored because the FSM is in REQ.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum and the constant INST_BYTES=4.
REQ-032 The block SHALL be a single module with no sub-modules; buf_write_en and buf_data connect directly to the write_en and data_in inputs of the instruction buffer.

Verification
REQ-033 Reset release, ready=1, response one cycle after each request -> addresses 0x0, 0x4, 0x8 are requested and each buf_data is written with matching fetch_pc.
REQ-034 buf_full=1 held for 5 cycles in REQ -> imem_req_valid=0 for all 5 cycles; after buf_full falls, a request to the same PC.
REQ-035 Redirect to 0x100 while in WAIT, response 2 cycles later -> that response is discarded, the next request address is 0x100, and there is no buf_write_en for the stale data.
REQ-036 Redirect to 0x203 coincident with a response -> no write; the next request address is 0x200.
REQ-037 RESET_PC=0xFFFFFFFC with one fetch -> the second request address is 0x00000000.
REQ-038 Reset asserted asynchronously in WAIT, response arriving after release -> no buf_write_en; the request address is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Bytes per instruction word; the sequential PC advances by this amount.
    localparam int INST_BYTES = 4;

    // Fetch FSM: issue a request, wait for its response, or discard a stale one.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Single-outstanding-request instruction fetch unit. Issues
//               PC-addressed memory requests, writes returned instructions
//               into the downstream buffer and handles branch redirects,
//               discarding responses that belong to a squashed request.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  buf_full,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  buf_write_en,
    output logic [INST_WIDTH-1:0] buf_data,
    output logic [ADDR_WIDTH-1:0] fetch_pc
);

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [ADDR_WIDTH-1:0] w_req_addr_next;
    logic                  r_buf_write_en;
    logic                  w_buf_write_en_next;
    logic [INST_WIDTH-1:0] r_buf_data;
    logic [INST_WIDTH-1:0] w_buf_data_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_next;
    logic [ADDR_WIDTH-1:0] w_redirect_aligned;
    logic [ADDR_WIDTH-1:0] w_pc_seq;
    logic                  w_handshake;
    logic                  w_unused_align_bits;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign w_redirect_aligned  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_align_bits = ^redirect_pc[1:0];
    // Wraps naturally modulo 2^ADDR_WIDTH.
    assign w_pc_seq            = r_req_addr + ADDR_WIDTH'(INST_BYTES);

    // A request is held off while a write is landing so that only one
    // instruction can be in flight and buffer space is always available.
    assign imem_req_valid = (r_state == ST_REQ) && !buf_full && !r_buf_write_en &&
                            !redirect_valid && !reset;
    assign imem_req_addr  = r_pc;
    assign w_handshake    = imem_req_valid && imem_req_ready;

    assign buf_write_en   = r_buf_write_en;
    assign buf_data       = r_buf_data;
    assign fetch_pc       = r_fetch_pc;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, latched request address and buffer write port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_req_addr     <= '0;
            r_buf_write_en <= 1'b0;
            r_buf_data     <= '0;
            r_fetch_pc     <= '0;
        end else begin
            r_pc           <= w_pc_next;
            r_req_addr     <= w_req_addr_next;
            r_buf_write_en <= w_buf_write_en_next;
            r_buf_data     <= w_buf_data_next;
            r_fetch_pc     <= w_fetch_pc_next;
        end
    end

    // Next-state, PC update and buffer write decisions.
    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_req_addr_next     = r_req_addr;
        w_buf_write_en_next = 1'b0;
        w_buf_data_next     = r_buf_data;
        w_fetch_pc_next     = r_fetch_pc;
        case (r_state)
            ST_REQ: begin
                // Responses seen here belong to no live request and are ignored.
                if (redirect_valid) begin
                    w_pc_next = w_redirect_aligned;
                end else if (w_handshake) begin
                    w_req_addr_next = r_pc;
                    w_state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    // A coincident response is the squashed one; otherwise it
                    // is still coming and must be dropped when it arrives.
                    w_pc_next    = w_redirect_aligned;
                    w_state_next = imem_resp_valid ? ST_REQ : ST_DROP;
                end else if (imem_resp_valid) begin
                    w_buf_write_en_next = 1'b1;
                    w_buf_data_next     = imem_resp_data;
                    w_fetch_pc_next     = r_req_addr;
                    w_pc_next           = w_pc_seq;
                    w_state_next        = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    w_pc_next = w_redirect_aligned;
                end
                if (imem_resp_valid) begin
                    w_state_next = ST_REQ;
                end
            end
            default: begin
                w_state_next = ST_REQ;
            end
        endcase
    end

endmodule
`default_nettype wire
